uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `UART_Tx` transmitter between `NREQ` byte producers. It picks a requester, loads its byte onto the transmitter's parallel input, and pulses the start strobe. It then holds off every other requester until the transmitter reports `Tx_Done_Tick`. It sits between the per-client TX FIFOs and the single `UART_Tx` instance.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 110 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: arbiter FSM encoding, default byte width, UART_Tx states.
// No ports; imported by the arbiter, its interface and benches.
package uart_pkg;

  localparam int DBITS_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } uart_tx_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the client FIFOs / UART_Tx and the arbiter.
// master: req, din, tx_done_tick out; slave: ack, tx_din, tx_start, busy, grant_id out.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBits = DBITS_DEF
);

  localparam int IW = clog2_min1(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ*DBits-1:0] din;
  logic [NREQ-1:0]       ack;
  logic [DBits-1:0]      tx_din;
  logic                  tx_start;
  logic                  tx_done_tick;
  logic                  busy;
  logic [IW-1:0]         grant_id;

  modport master (
    output req, din, tx_done_tick,
    input  ack, tx_din, tx_start, busy, grant_id
  );

  modport slave (
    input  req, din, tx_done_tick,
    output ack, tx_din, tx_start, busy, grant_id
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit after last, wrapping.
// Ports: req, last in; winner, any out.
module rr_pick
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [IW-1:0]   winner,
  output logic            any
);

  always_comb begin
    winner = '0;
    any    = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(last) + i) % NREQ]) begin
        any    = 1'b1;
        winner = IW'((int'(last) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART_Tx among NREQ byte producers.
// Ports: clk, areset (async, active low), bus (slave); UART_TX_ARB_BURST_EN enables bursts.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DBits     = DBITS_DEF,
  parameter int BURST_LEN = 4
) (
  input logic              clk,
  input logic              areset,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = clog2_min1(NREQ);

  if (NREQ < 2 || BURST_LEN < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: bad NREQ/BURST_LEN");
  end

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [DBits-1:0] tx_din_q, tx_din_d;
  logic [IW-1:0]    winner;
  logic             any;

`ifdef UART_TX_ARB_BURST_EN
  localparam int CW = $clog2(BURST_LEN) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q  <= ARB_IDLE;
      last_q   <= IW'(NREQ - 1);
      grant_q  <= '0;
      tx_din_q <= '0;
`ifdef UART_TX_ARB_BURST_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      tx_din_q <= tx_din_d;
`ifdef UART_TX_ARB_BURST_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    tx_din_d = tx_din_q;
`ifdef UART_TX_ARB_BURST_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (any) begin
          last_d   = winner;
          grant_d  = winner;
          tx_din_d = bus.din[int'(winner)*DBits +: DBits];
          state_d  = ARB_LOAD;
        end
      end
      ARB_LOAD: state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (bus.tx_done_tick) begin
`ifdef UART_TX_ARB_BURST_EN
          // Same requester keeps the line; pointer stays put.
          if (bus.req[grant_q] &&
              cnt_q < CW'(BURST_LEN - 1)) begin
            cnt_d    = cnt_q + CW'(1);
            tx_din_d = bus.din[int'(grant_q)*DBits +: DBits];
            state_d  = ARB_LOAD;
          end else begin
            cnt_d   = '0;
            state_d = ARB_IDLE;
          end
`else
          state_d = ARB_IDLE;
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.ack = '0;
    if (state_q == ARB_LOAD) bus.ack[grant_q] = 1'b1;
  end

  assign bus.tx_start = (state_q == ARB_LOAD);
  assign bus.busy     = (state_q != ARB_IDLE);
  assign bus.tx_din   = tx_din_q;
  assign bus.grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a grant scoreboard.
// Drives on negedge, checks on negedge; UART_Tx modelled by done pulses.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int NREQ = 4;
  localparam int DB   = 8;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBits(DB)) bus();

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBits(DB), .BURST_LEN(4)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [7:0] dv [NREQ];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic set_din(input logic [7:0] d0, d1, d2, d3);
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    bus.din = {d3, d2, d1, d0};
  endtask

  task automatic expect_grant(input int id);
    exp_t e;
    e.id   = 2'(id);
    e.data = dv[id];
    sb.push_back(e);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.tx_done_tick = 1'b0;
    @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    areset = 1'b1;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (bus.tx_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(bus.tx_start), 1);
  endtask

  task automatic do_byte(input int hold, input bit drop);
    wait_start("start_seen");
    check("busy_load", 32'(bus.busy), 1);
    if (drop) bus.req = '0;
    @(negedge clk);
    repeat (hold) begin
      check("busy_wait", 32'(bus.busy), 1);
      @(negedge clk);
    end
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
  endtask

  always @(negedge clk) begin
    if (areset && bus.tx_start === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_start", 32'(sb.size()), 1);
      end else begin
        mon_e = sb.pop_front();
        check("ack", 32'(bus.ack), 32'(1) << mon_e.id);
        check("tx_din", 32'(bus.tx_din), 32'(mon_e.data));
        check("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
      end
    end else if (areset && bus.ack !== '0) begin
      check("stray_ack", 32'(bus.ack), 0);
    end
  end

  initial begin
    bus.req = '0;
    bus.din = '0;
    bus.tx_done_tick = 1'b0;
    set_din(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_start", 32'(bus.tx_start), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_txdin", 32'(bus.tx_din), 0);
    check("rst_gid", 32'(bus.grant_id), 0);
    areset = 1'b1;

    // single byte, latency and busy window
    set_din(8'hA5, 8'h22, 8'h33, 8'h44);
    expect_grant(0);
    bus.req = 4'b0001;
    @(negedge clk);
    check("t1_latency", 32'(bus.tx_start), 1);
    check("t1_txdin", 32'(bus.tx_din), 32'h0A5);
    do_byte(3, 1'b1);
    check("t1_busy_after", 32'(bus.busy), 0);

    // all requesting: rotate
    do_reset();
    set_din(8'h11, 8'h22, 8'h33, 8'h44);
`ifdef UART_TX_ARB_BURST_EN
    expect_grant(0); expect_grant(0); expect_grant(0);
    expect_grant(0); expect_grant(1);
`else
    expect_grant(0); expect_grant(1); expect_grant(2);
    expect_grant(3); expect_grant(0);
`endif
    bus.req = 4'b1111;
    repeat (5) do_byte(2, 1'b0);
    bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    check("t2_idle", 32'(bus.busy), 0);

    // wrap to 3, then 0
    do_reset();
    set_din(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    expect_grant(3);
    bus.req = 4'b1000;
    do_byte(1, 1'b1);
    expect_grant(3);
    bus.req = 4'b1000;
    do_byte(1, 1'b1);
    expect_grant(0);
    bus.req = 4'b1001;
    do_byte(1, 1'b1);
    @(negedge clk);

    // done tick in IDLE ignored
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    check("t4_idle_busy", 32'(bus.busy), 0);
    check("t4_idle_start", 32'(bus.tx_start), 0);
    check("t4_idle_gid", 32'(bus.grant_id), 0);
    @(negedge clk);
    check("t4_idle_start2", 32'(bus.tx_start), 0);

    // done tick in LOAD ignored
    expect_grant(2);
    bus.req = 4'b0100;
    wait_start("t4_load_start");
    bus.tx_done_tick = 1'b1;
    bus.req = '0;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    check("t4_load_busy", 32'(bus.busy), 1);
    check("t4_load_nostart", 32'(bus.tx_start), 0);
    @(negedge clk);
    check("t4_load_busy2", 32'(bus.busy), 1);
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
    check("t4_end_busy", 32'(bus.busy), 0);

    // reset during WAIT of requester 2
    set_din(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    expect_grant(2);
    bus.req = 4'b0100;
    wait_start("t5_start");
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", 32'(bus.busy), 1);
    areset = 1'b0;
    #1;
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_start", 32'(bus.tx_start), 0);
    check("t5_rst_ack", 32'(bus.ack), 0);
    check("t5_rst_txdin", 32'(bus.tx_din), 0);
    check("t5_rst_gid", 32'(bus.grant_id), 0);
    @(negedge clk);
    expect_grant(2);
    areset = 1'b1;
    do_byte(1, 1'b1);

    // two requesters held
    do_reset();
    set_din(8'h01, 8'h02, 8'h03, 8'h04);
`ifdef UART_TX_ARB_BURST_EN
    for (int i = 0; i < 8; i++) expect_grant(i / 4);
`else
    for (int i = 0; i < 8; i++) expect_grant(i % 2);
`endif
    bus.req = 4'b0011;
    repeat (8) do_byte(1, 1'b0);
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("t6_idle", 32'(bus.busy), 0);

    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
